issue_queue: RTL

ISSUE_QUEUE -- requirements
Module: issue_queue

---
 rtl/issue_queue_pkg.sv | 22 ++
 rtl/issue_queue_entry.sv | 104 ++++++++++
 rtl/issue_queue.sv | 138 +++++++++++++
 3 files changed

// File: rtl/issue_queue_pkg.sv
// Shared core constants: queue geometry, field widths and opcode class encodings.
// No logic; pure compile-time definitions.
// Not applicable (no handshake).
package issue_queue_pkg;

    localparam int IQ_ENTRIES = 16;
    localparam int OPCODE_W   = 7;
    localparam int AGE_W      = 5;
    localparam int TAG_W      = 6;
    localparam int UOP_W      = 32;
    localparam int NUM_GNT_P  = 2;
    localparam int COUNT_W    = 5;

    // Opcode class encodings carried in the op field and seen by the arbiter.
    localparam logic [OPCODE_W-1:0] R_TYPE = 7'b0110011;
    localparam logic [OPCODE_W-1:0] I_TYPE = 7'b0010011;
    localparam logic [OPCODE_W-1:0] LOAD   = 7'b0000011;
    localparam logic [OPCODE_W-1:0] STORE  = 7'b0100011;
    localparam logic [OPCODE_W-1:0] BRANCH = 7'b1100011;
    localparam logic [OPCODE_W-1:0] MUL    = 7'b0111011;

endpackage

// File: rtl/issue_queue_entry.sv
// One issue queue slot: payload storage, operand readiness and tag wakeup compare.
// Writes/frees/wakeups take effect at the next clock edge; req is purely registered.
// No handshake of its own; the parent decides when to write or free the slot.
module iq_entry
    import issue_queue_pkg::*;
#(
    parameter int OPCODE_WIDTH = OPCODE_W,
    parameter int AGE_WIDTH    = AGE_W,
    parameter int TAG_WIDTH    = TAG_W,
    parameter int UOP_WIDTH    = UOP_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    input  logic                    wr_en,
    input  logic [OPCODE_WIDTH-1:0] wr_op,
    input  logic [UOP_WIDTH-1:0]    wr_uop,
    input  logic [TAG_WIDTH-1:0]    wr_rs1_tag,
    input  logic                    wr_rs1_rdy,
    input  logic [TAG_WIDTH-1:0]    wr_rs2_tag,
    input  logic                    wr_rs2_rdy,
    input  logic [AGE_WIDTH-1:0]    wr_age,
    input  logic                    free,
    input  logic [AGE_WIDTH-1:0]    age_nxt,
    input  logic                    wk_valid,
    input  logic [TAG_WIDTH-1:0]    wk_tag,
    output logic                    valid_o,
    output logic [OPCODE_WIDTH-1:0] op_o,
    output logic [UOP_WIDTH-1:0]    uop_o,
    output logic [AGE_WIDTH-1:0]    age_o,
    output logic                    req_o
);

    logic                    valid_q, valid_d;
    logic [OPCODE_WIDTH-1:0] op_q, op_d;
    logic [UOP_WIDTH-1:0]    uop_q, uop_d;
    logic [TAG_WIDTH-1:0]    rs1_tag_q, rs1_tag_d;
    logic [TAG_WIDTH-1:0]    rs2_tag_q, rs2_tag_d;
    logic                    rs1_rdy_q, rs1_rdy_d;
    logic                    rs2_rdy_q, rs2_rdy_d;
    logic [AGE_WIDTH-1:0]    age_q, age_d;

    // Next-state: flush wins, then a fresh write (with wakeup folded in), then free/age/wakeup.
    always_comb begin
        valid_d   = valid_q;
        op_d      = op_q;
        uop_d     = uop_q;
        rs1_tag_d = rs1_tag_q;
        rs2_tag_d = rs2_tag_q;
        rs1_rdy_d = rs1_rdy_q;
        rs2_rdy_d = rs2_rdy_q;
        age_d     = age_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (wr_en) begin
            valid_d   = 1'b1;
            op_d      = wr_op;
            uop_d     = wr_uop;
            rs1_tag_d = wr_rs1_tag;
            rs2_tag_d = wr_rs2_tag;
            rs1_rdy_d = wr_rs1_rdy | (wk_valid & (wr_rs1_tag == wk_tag));
            rs2_rdy_d = wr_rs2_rdy | (wk_valid & (wr_rs2_tag == wk_tag));
            age_d     = wr_age;
        end else if (valid_q) begin
            if (free) begin
                valid_d = 1'b0;
            end else begin
                age_d = age_nxt;
            end
            if (wk_valid && (rs1_tag_q == wk_tag)) rs1_rdy_d = 1'b1;
            if (wk_valid && (rs2_tag_q == wk_tag)) rs2_rdy_d = 1'b1;
        end
    end

    // Slot state registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            op_q      <= '0;
            uop_q     <= '0;
            rs1_tag_q <= '0;
            rs2_tag_q <= '0;
            rs1_rdy_q <= 1'b0;
            rs2_rdy_q <= 1'b0;
            age_q     <= '0;
        end else begin
            valid_q   <= valid_d;
            op_q      <= op_d;
            uop_q     <= uop_d;
            rs1_tag_q <= rs1_tag_d;
            rs2_tag_q <= rs2_tag_d;
            rs1_rdy_q <= rs1_rdy_d;
            rs2_rdy_q <= rs2_rdy_d;
            age_q     <= age_d;
        end
    end

    assign valid_o = valid_q;
    assign op_o    = op_q;
    assign uop_o   = uop_q;
    assign age_o   = age_q;
    assign req_o   = valid_q & rs1_rdy_q & rs2_rdy_q;

endmodule

// File: rtl/issue_queue.sv
// Age-ordered issue queue: dispatch allocation, wakeup, multi-port grant/issue, dense ages.
// Dispatch/grant/wakeup visible one cycle later; iss_* read combinationally in grant cycle.
// disp_ready drops when full (registered count) or during flush; frees are not credited same cycle.
module issue_queue
    import issue_queue_pkg::*;
#(
    parameter int ENTRIES      = IQ_ENTRIES,
    parameter int OPCODE_WIDTH = OPCODE_W,
    parameter int AGE_WIDTH    = AGE_W,
    parameter int TAG_WIDTH    = TAG_W,
    parameter int UOP_WIDTH    = UOP_W,
    parameter int NUM_GNT      = NUM_GNT_P
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    disp_valid,
    output logic                    disp_ready,
    input  logic [OPCODE_WIDTH-1:0] disp_op,
    input  logic [UOP_WIDTH-1:0]    disp_uop,
    input  logic [TAG_WIDTH-1:0]    disp_rs1_tag,
    input  logic [TAG_WIDTH-1:0]    disp_rs2_tag,
    input  logic                    disp_rs1_rdy,
    input  logic                    disp_rs2_rdy,
    input  logic                    wk_valid,
    input  logic [TAG_WIDTH-1:0]    wk_tag,
    output logic [OPCODE_WIDTH-1:0] op     [ENTRIES],
    output logic [ENTRIES-1:0]      req,
    output logic [AGE_WIDTH-1:0]    age    [ENTRIES],
    input  logic [NUM_GNT-1:0]      gnt_valid,
    input  logic [3:0]              gnt_addr [NUM_GNT],
    output logic [UOP_WIDTH-1:0]    iss_uop  [NUM_GNT],
    output logic [OPCODE_WIDTH-1:0] iss_op   [NUM_GNT],
    input  logic                    flush,
    output logic [COUNT_W-1:0]      count
);

    localparam logic [COUNT_W-1:0] ENTRIES_C = COUNT_W'(ENTRIES);

    logic [ENTRIES-1:0]      ent_valid;
    logic [UOP_WIDTH-1:0]    ent_uop  [ENTRIES];
    logic [ENTRIES-1:0]      ent_wr;
    logic [ENTRIES-1:0]      ent_free;
    logic [AGE_WIDTH-1:0]    age_nxt  [ENTRIES];
    logic [NUM_GNT-1:0]      gnt_acc;
    logic [AGE_WIDTH-1:0]    gnt_age  [NUM_GNT];
    logic [COUNT_W-1:0]      n_freed;
    logic [3:0]              alloc_idx;
    logic                    disp_acc;
    logic [AGE_WIDTH-1:0]    new_age;
    logic [COUNT_W-1:0]      count_q, count_d;

    // Ready is masked by reset so nothing is offered while the queue is held in reset.
    assign disp_ready = rst_n & (count_q < ENTRIES_C) & ~flush;
    assign disp_acc   = disp_valid & disp_ready;
    assign count      = count_q;

    // Grant filtering: drop grants to empty slots and duplicates of an earlier port.
    always_comb begin
        gnt_acc = '0;
        n_freed = '0;
        for (int g = 0; g < NUM_GNT; g++) begin
            gnt_acc[g] = gnt_valid[g] & ent_valid[gnt_addr[g]];
            for (int h = 0; h < g; h++) begin
                if (gnt_valid[h] && (gnt_addr[h] == gnt_addr[g])) gnt_acc[g] = 1'b0;
            end
            gnt_age[g] = age[gnt_addr[g]];
            iss_uop[g] = ent_uop[gnt_addr[g]];
            iss_op[g]  = op[gnt_addr[g]];
            n_freed    = n_freed + COUNT_W'(gnt_acc[g]);
        end
    end

    // Per-slot free strobe and age compaction: drop one for every older slot leaving.
    always_comb begin
        for (int i = 0; i < ENTRIES; i++) begin
            ent_free[i] = 1'b0;
            age_nxt[i]  = age[i];
            for (int g = 0; g < NUM_GNT; g++) begin
                if (gnt_acc[g] && (gnt_addr[g] == 4'(i))) ent_free[i] = 1'b1;
                if (gnt_acc[g] && (gnt_age[g] < age[i])) age_nxt[i] = age_nxt[i] - AGE_WIDTH'(1);
            end
        end
    end

    // Allocation: lowest-index empty slot receives the dispatched op, youngest age.
    always_comb begin
        alloc_idx = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (!ent_valid[i]) alloc_idx = 4'(i);
        end
        ent_wr = '0;
        if (disp_acc) ent_wr[alloc_idx] = 1'b1;
        new_age = AGE_WIDTH'(count_q - n_freed);
    end

    // Occupancy bookkeeping; flush empties the queue outright.
    always_comb begin
        if (flush) count_d = '0;
        else       count_d = count_q + COUNT_W'(disp_acc) - n_freed;
    end

    // Occupancy register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) count_q <= '0;
        else        count_q <= count_d;
    end

    for (genvar i = 0; i < ENTRIES; i++) begin : g_ent
        iq_entry #(
            .OPCODE_WIDTH (OPCODE_WIDTH),
            .AGE_WIDTH    (AGE_WIDTH),
            .TAG_WIDTH    (TAG_WIDTH),
            .UOP_WIDTH    (UOP_WIDTH)
        ) u_ent (
            .clk        (clk),
            .rst_n      (rst_n),
            .flush      (flush),
            .wr_en      (ent_wr[i]),
            .wr_op      (disp_op),
            .wr_uop     (disp_uop),
            .wr_rs1_tag (disp_rs1_tag),
            .wr_rs1_rdy (disp_rs1_rdy),
            .wr_rs2_tag (disp_rs2_tag),
            .wr_rs2_rdy (disp_rs2_rdy),
            .wr_age     (new_age),
            .free       (ent_free[i]),
            .age_nxt    (age_nxt[i]),
            .wk_valid   (wk_valid),
            .wk_tag     (wk_tag),
            .valid_o    (ent_valid[i]),
            .op_o       (op[i]),
            .uop_o      (ent_uop[i]),
            .age_o      (age[i]),
            .req_o      (req[i])
        );
    end

endmodule
